// File: rtl/card_timer_scheduler.sv
// card_timer_scheduler: round-robin grant of one shared hold-window timer,
// latching a free-running 1..13 card value at each grant.
module card_timer_scheduler #(
    parameter int N_REQ      = 3,
    parameter int TICK_DIV   = 25000,
    parameter int HOLD_TICKS = 4000,
    parameter int COUNT_W    = 12
) (
    input  logic               clk_50M,
    input  logic               i_Reset,
    input  logic [N_REQ-1:0]   i_Req,
    output logic [N_REQ-1:0]   o_Grant,
    output logic [N_REQ-1:0]   o_Done,
    output logic               o_Busy,
    output logic [3:0]         o_Card,
    output logic [COUNT_W-1:0] o_Count
);
    localparam int IDX_W = N_REQ > 1 ? $clog2(N_REQ) : 1;
    localparam int PRE_W = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
    state_t state, state_n;
    logic [IDX_W-1:0] idx, idx_n, rr, rr_n, rr_next, off, pick;
    logic [IDX_W:0] sum;
    logic [N_REQ-1:0] rot, idx_hot;
    logic [PRE_W-1:0] pre, pre_n;
    logic [COUNT_W-1:0] count_n;
    logic [3:0] card_n, r_rand;
    logic found, tick, last;

    assign idx_hot = N_REQ'(1) << idx;
    assign o_Grant = state == WAIT ? idx_hot : '0;
    assign o_Done  = state == DONE ? idx_hot : '0;
    assign o_Busy  = state != IDLE;
    assign rr_next = idx == IDX_W'(N_REQ - 1) ? '0 : idx + 1'b1;

    // Rotate requests so bit 0 is the round-robin pointer, then un-rotate the winner.
    always_comb begin
        rot = N_REQ'({i_Req, i_Req} >> rr);
        off = '0;
        for (int k = N_REQ - 1; k >= 0; k--)
            if (rot[k]) off = IDX_W'(k);
        found = |i_Req;
        sum = {1'b0, rr} + {1'b0, off};
        pick = sum >= (IDX_W + 1)'(N_REQ) ? IDX_W'(sum - (IDX_W + 1)'(N_REQ)) : IDX_W'(sum);
    end

    always_comb begin
        state_n = state;
        idx_n = idx;
        rr_n = rr;
        pre_n = pre;
        count_n = o_Count;
        card_n = o_Card;
        tick = pre == PRE_W'(TICK_DIV - 1);
        last = o_Count == COUNT_W'(HOLD_TICKS - 1);
        case (state)
            IDLE: if (found) begin
                state_n = WAIT;
                idx_n = pick;
                card_n = r_rand;
                count_n = '0;
                pre_n = '0;
            end
            WAIT: if (!i_Req[idx]) begin
                state_n = IDLE;
                rr_n = rr_next;
            end else begin
                pre_n = tick ? '0 : pre + 1'b1;
                if (tick && last) state_n = DONE;
                else if (tick) count_n = o_Count + 1'b1;
            end
            DONE: begin
                state_n = IDLE;
                rr_n = rr_next;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk_50M or posedge i_Reset) begin
        if (i_Reset) begin
            state <= IDLE;
            idx <= '0;
            rr <= '0;
            pre <= '0;
            o_Count <= '0;
            o_Card <= '0;
            r_rand <= 4'd1;
        end else begin
            state <= state_n;
            idx <= idx_n;
            rr <= rr_n;
            pre <= pre_n;
            o_Count <= count_n;
            o_Card <= card_n;
            r_rand <= r_rand == 4'd13 ? 4'd1 : r_rand + 4'd1;
        end
    end
endmodule

// File: tb/tb_card_timer_scheduler.sv
// tb_card_timer_scheduler: window-level reference model with per-cycle compare,
// directed literal scenarios and a randomized requester phase.
module tb_card_timer_scheduler;
    localparam int N = 3, DIV = 4, HOLD = 3;
    logic clk = 1'b0, rst = 1'b1;
    logic [N-1:0] req = '0;
    logic [N-1:0] grant, done;
    logic busy;
    logic [3:0] card;
    logic [11:0] count;
    int n_cmp = 0, n_bad = 0;
    int m_owner = -1, m_done = -1, m_el = 0, m_ptr = 0, m_cyc = 0, m_card = 0, m_count = 0;

    card_timer_scheduler #(.N_REQ(N), .TICK_DIV(DIV), .HOLD_TICKS(HOLD), .COUNT_W(12)) dut (
        .clk_50M(clk), .i_Reset(rst), .i_Req(req), .o_Grant(grant), .o_Done(done),
        .o_Busy(busy), .o_Card(card), .o_Count(count));

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // Model: owner holds the timer for HOLD*DIV cycles; card is the free-running value at grant.
    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            m_owner = -1; m_done = -1; m_el = 0; m_ptr = 0; m_cyc = 0; m_card = 0; m_count = 0;
        end else begin
            if (m_done >= 0) m_done = -1;
            else if (m_owner >= 0) begin
                if (!req[m_owner]) begin
                    m_ptr = (m_owner + 1) % N;
                    m_owner = -1;
                end else begin
                    m_el++;
                    if (m_el == HOLD * DIV) begin
                        m_done = m_owner;
                        m_ptr = (m_owner + 1) % N;
                        m_owner = -1;
                    end else m_count = m_el / DIV;
                end
            end else begin
                for (int k = 0; k < N; k++)
                    if (m_owner < 0 && req[(m_ptr + k) % N]) begin
                        m_owner = (m_ptr + k) % N;
                        m_el = 0;
                        m_count = 0;
                        m_card = m_cyc % 13 + 1;
                    end
            end
            m_cyc++;
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        chk("grant", int'(grant), m_owner >= 0 ? 1 << m_owner : 0);
        chk("done", int'(done), m_done >= 0 ? 1 << m_done : 0);
        chk("busy", int'(busy), int'(m_owner >= 0 || m_done >= 0));
        chk("card", int'(card), m_card);
        chk("count", int'(count), m_count);
    end

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        // single requester full window
        do_reset();
        req = 3'b001;
        step(1);
        chk("t1_grant", int'(grant), 1);
        chk("t1_card", int'(card), 1);
        chk("t1_count0", int'(count), 0);
        step(4);
        chk("t1_count1", int'(count), 1);
        step(4);
        chk("t1_count2", int'(count), 2);
        step(3);
        chk("t1_grant_last", int'(grant), 1);
        chk("t1_busy", int'(busy), 1);
        step(1);
        chk("t1_done", int'(done), 1);
        chk("t1_grant_off", int'(grant), 0);
        chk("t1_busy_done", int'(busy), 1);
        req = '0;
        step(1);
        chk("t1_done_off", int'(done), 0);
        chk("t1_idle", int'(busy), 0);
        chk("t1_count_hold", int'(count), 2);
        // all three request, each drops after done
        do_reset();
        req = 3'b111;
        step(13);
        chk("t2_done0", int'(done), 1);
        req[0] = 1'b0;
        step(1);
        chk("t2_gap", int'(grant), 0);
        step(1);
        chk("t2_grant1", int'(grant), 2);
        step(12);
        chk("t2_done1", int'(done), 2);
        req[1] = 1'b0;
        step(2);
        chk("t2_grant2", int'(grant), 4);
        // continuous pair alternates
        do_reset();
        req = 3'b011;
        step(1);
        chk("t3_g0", int'(grant), 1);
        step(14);
        chk("t3_g1", int'(grant), 2);
        step(14);
        chk("t3_g2", int'(grant), 1);
        step(14);
        chk("t3_g3", int'(grant), 2);
        // abort mid-window
        do_reset();
        req = 3'b001;
        step(5);
        req = '0;
        step(1);
        chk("t4_abort_grant", int'(grant), 0);
        chk("t4_abort_done", int'(done), 0);
        req = 3'b011;
        step(1);
        chk("t4_next", int'(grant), 2);
        // asynchronous reset mid-window
        do_reset();
        req = 3'b100;
        step(4);
        rst = 1'b1;
        #1;
        chk("t5_grant", int'(grant), 0);
        chk("t5_busy", int'(busy), 0);
        chk("t5_card", int'(card), 0);
        chk("t5_count", int'(count), 0);
        chk("t5_done", int'(done), 0);
        @(negedge clk);
        rst = 1'b0;
        step(1);
        chk("t5_regrant", int'(grant), 4);
        step(11);
        chk("t5_full", int'(grant), 4);
        step(1);
        chk("t5_done_end", int'(done), 4);
        // card value versus grant offset
        for (int d = 0; d <= 12; d++) begin
            do_reset();
            step(d);
            req = 3'b001;
            step(1);
            chk("t6_card", int'(card), d + 1);
            req = '0;
            step(1);
        end
        // randomized requesters against the model
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                if (m_done == i) req[i] = $urandom_range(0, 5) == 0;
                else if (!req[i]) req[i] = $urandom_range(0, 9) == 0;
                else if (m_owner == i && $urandom_range(0, 149) == 0) req[i] = 1'b0;
            end
            if ($urandom_range(0, 999) == 0) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
            end
        end
        step(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
